// File: rtl/mips_encode_queue_if.sv
// mips_encode_queue_if: request and drain handshake bundle for the MIPS word encoder queue
interface mips_encode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src2;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm16;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        err;
  modport master (
    output in_valid, alu_op, alu_src2, rd, rs, rt, imm16, out_ready,
    input  in_ready, out_valid, out_inst, err
  );
  modport slave (
    input  in_valid, alu_op, alu_src2, rd, rs, rt, imm16, out_ready,
    output in_ready, out_valid, out_inst, err
  );
endinterface

// File: rtl/mips_encode_queue.sv
// mips_encode_queue: encodes control requests into MIPS words and buffers them in a FIFO
// Optional MIPS_ENC_COUNT_EN adds num_enc/num_err accept counters.
module mips_encode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_encode_queue_if.slave   q
`ifdef MIPS_ENC_COUNT_EN
  ,
  output logic [15:0]          num_enc,
  output logic [15:0]          num_err
`endif
);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, empty, push, pop, legal, wr_en;
  logic [5:0] funct, iop;
  logic [31:0] word;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign q.out_inst  = empty ? 32'h0 : mem[rd_ptr];
  assign push  = q.in_valid & ~full;
  assign pop   = q.out_ready & ~empty;
  assign wr_en = push & legal;
  always_comb begin
    funct = q.alu_op == 3'd2 ? 6'h20 : q.alu_op == 3'd3 ? 6'h22 : q.alu_op == 3'd4 ? 6'h24 :
            q.alu_op == 3'd5 ? 6'h25 : q.alu_op == 3'd6 ? 6'h27 : 6'h26;
    iop   = q.alu_op == 3'd4 ? 6'h0c : q.alu_op == 3'd5 ? 6'h0d : 6'h0e;
    legal = (q.alu_src2 == 2'd0 && q.alu_op >= 3'd2) ||
            (q.alu_src2 == 2'd1 && q.alu_op == 3'd2) ||
            (q.alu_src2 == 2'd2 && (q.alu_op == 3'd4 || q.alu_op == 3'd5 || q.alu_op == 3'd7));
    word  = q.alu_src2 == 2'd0 ? {6'h00, q.rs, q.rt, q.rd, 5'h00, funct}
                               : {q.alu_src2 == 2'd1 ? 6'h08 : iop, q.rs, q.rd, q.imm16};
  end
  always_ff @(posedge clock)
    if (wr_en) mem[wr_ptr] <= word;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q.err  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
      q.err  <= push & ~legal;
    end
  end
`ifdef MIPS_ENC_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      num_enc <= '0;
      num_err <= '0;
    end else begin
      num_enc <= num_enc + 16'(wr_en);
      num_err <= num_err + 16'(push & ~legal);
    end
  end
`endif
endmodule
